// File: rtl/chip_7458_if.sv
// Bus interface for chip_7458: the ten gate inputs and the four results.
//   master: drives p1a..p1f and p2a..p2d, observes p1y, p2y, p1y_c and p2y_c.
//   slave : the 7458 cell itself; it consumes the inputs and drives the results.
interface chip_7458_if;
  logic p1a, p1b, p1c, p1d, p1e, p1f;
  logic p2a, p2b, p2c, p2d;
  logic p1y, p2y;
  logic p1y_c, p2y_c;

  modport master (
    output p1a, p1b, p1c, p1d, p1e, p1f,
    output p2a, p2b, p2c, p2d,
    input  p1y, p2y, p1y_c, p2y_c
  );

  modport slave (
    input  p1a, p1b, p1c, p1d, p1e, p1f,
    input  p2a, p2b, p2c, p2d,
    output p1y, p2y, p1y_c, p2y_c
  );
endinterface

// File: rtl/chip_7458.sv
// chip_7458: dual AND-OR glue cell (7458 function).
//   Gate 1: p1y = (p1a & p1b & p1c) | (p1d & p1e & p1f)
//   Gate 2: p2y = (p2a & p2b) | (p2c & p2d)
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, clears the registered results
//   bus   - chip_7458_if.slave: gate inputs in; p1y/p2y (registered when
//           REG_OUT=1, combinational otherwise) and p1y_c/p2y_c (always
//           combinational) out
module chip_7458 #(
  parameter bit REG_OUT = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  chip_7458_if.slave bus
);

  logic p1y_c;
  logic p2y_c;

  // Raw AND-OR results; inputs pass through untouched so X/Z propagate.
  always_comb begin
    p1y_c = (bus.p1a & bus.p1b & bus.p1c) | (bus.p1d & bus.p1e & bus.p1f);
    p2y_c = (bus.p2a & bus.p2b) | (bus.p2c & bus.p2d);
  end

  assign bus.p1y_c = p1y_c;
  assign bus.p2y_c = p2y_c;

  if (REG_OUT) begin : g_reg
    logic p1y_q;
    logic p2y_q;

    // One-cycle registered copy of both gates; reset forces both low.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        p1y_q <= 1'b0;
        p2y_q <= 1'b0;
      end else begin
        p1y_q <= p1y_c;
        p2y_q <= p2y_c;
      end
    end

    assign bus.p1y = p1y_q;
    assign bus.p2y = p2y_q;
  end else begin : g_comb
    // Pure combinational build: clock and reset play no part.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign bus.p1y = p1y_c;
    assign bus.p2y = p2y_c;
  end

endmodule

// File: tb/tb_chip_7458.sv
// Testbench for chip_7458: a registered (REG_OUT=1) and a combinational
// (REG_OUT=0) instance driven with the same vectors, checked against a
// group-counting reference model plus hand-computed directed expectations.
module tb_chip_7458;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;

  // g1 = {p1a,p1b,p1c,p1d,p1e,p1f}, g2 = {p2a,p2b,p2c,p2d}
  logic [5:0] g1 = '0;
  logic [3:0] g2 = '0;

  int checks = 0;
  int errors = 0;

  // Model state for the registered instance.
  logic m1 = 1'b0;
  logic m2 = 1'b0;
  logic mvalid = 1'b0;

  chip_7458_if bus1 ();
  chip_7458_if bus0 ();

  chip_7458 #(.REG_OUT(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus1));
  chip_7458 #(.REG_OUT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 if (clk_en) clk = ~clk;

  // A gate is high when any of its AND groups has every member set.
  function automatic logic gate1(input logic [5:0] v);
    return ($countones(v[5:3]) == 3) || ($countones(v[2:0]) == 3);
  endfunction

  function automatic logic gate2(input logic [3:0] v);
    return ($countones(v[3:2]) == 2) || ($countones(v[1:0]) == 2);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [5:0] a, input logic [3:0] b);
    g1 = a;
    g2 = b;
    {bus1.p1a, bus1.p1b, bus1.p1c, bus1.p1d, bus1.p1e, bus1.p1f} = a;
    {bus1.p2a, bus1.p2b, bus1.p2c, bus1.p2d} = b;
    {bus0.p1a, bus0.p1b, bus0.p1c, bus0.p1d, bus0.p1e, bus0.p1f} = a;
    {bus0.p2a, bus0.p2b, bus0.p2c, bus0.p2d} = b;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: each edge captures the gate values, or 0 under reset.
  always @(posedge clk) begin
    m1 <= rst_n ? gate1(g1) : 1'b0;
    m2 <= rst_n ? gate2(g2) : 1'b0;
    mvalid <= 1'b1;
  end

  // Every-cycle comparison on the falling edge, away from input changes.
  always @(negedge clk) begin
    if (mvalid) begin
      check("model_p1y", bus1.p1y, m1);
      check("model_p2y", bus1.p2y, m2);
      check("model_p1y_c", bus1.p1y_c, gate1(g1));
      check("model_p2y_c", bus1.p2y_c, gate2(g2));
      check("model_comb_p1y", bus0.p1y, gate1(g1));
      check("model_comb_p2y", bus0.p2y, gate2(g2));
    end
  end

  initial begin
    set_in(6'b000000, 4'b0000);
    tick();
    check("reset_p1y", bus1.p1y, 1'b0);
    check("reset_p2y", bus1.p2y, 1'b0);
    rst_n = 1'b1;

    // All zero inputs.
    set_in(6'b000000, 4'b0000);
    #1;
    check("zero_p1y_c", bus1.p1y_c, 1'b0);
    check("zero_p2y_c", bus1.p2y_c, 1'b0);
    tick();
    check("zero_p1y", bus1.p1y, 1'b0);
    check("zero_p2y", bus1.p2y, 1'b0);

    // Gate 1 first group.
    set_in(6'b111000, 4'b0000);
    #1;
    check("g1a_p1y_c", bus1.p1y_c, 1'b1);
    check("g1a_p1y_before_edge", bus1.p1y, 1'b0);
    tick();
    check("g1a_p1y", bus1.p1y, 1'b1);
    check("g1a_p2y", bus1.p2y, 1'b0);

    // Gate 1 second group.
    set_in(6'b000111, 4'b0000);
    tick();
    check("g1b_p1y", bus1.p1y, 1'b1);

    // Drop p1f: partial group contributes nothing.
    set_in(6'b000110, 4'b0000);
    #1;
    check("g1b_partial_p1y_c", bus1.p1y_c, 1'b0);
    tick();
    check("g1b_partial_p1y", bus1.p1y, 1'b0);

    // Gate 2 groups; gate 1 held high to show independence.
    set_in(6'b111000, 4'b1100);
    tick();
    check("g2a_p2y", bus1.p2y, 1'b1);
    set_in(6'b111000, 4'b0011);
    tick();
    check("g2b_p2y", bus1.p2y, 1'b1);
    set_in(6'b111000, 4'b0000);
    tick();
    check("g2_off_p2y", bus1.p2y, 1'b0);
    check("g2_off_p1y", bus1.p1y, 1'b1);

    // Both groups true at once.
    set_in(6'b111111, 4'b1111);
    tick();
    check("both_p1y", bus1.p1y, 1'b1);
    check("both_p2y", bus1.p2y, 1'b1);

    // A glitch that reverts before the edge is not captured.
    set_in(6'b000000, 4'b0000);
    #1;
    set_in(6'b111000, 4'b1100);
    #1;
    set_in(6'b000000, 4'b0000);
    tick();
    check("glitch_p1y", bus1.p1y, 1'b0);
    check("glitch_p2y", bus1.p2y, 1'b0);

    // Exhaustive sweep; gate 2 sees all 16 patterns four times over.
    for (int i = 0; i < 64; i++) begin
      set_in(6'(i), 4'(i));
      #1;
      check("sweep_p1y_c", bus1.p1y_c, gate1(6'(i)));
      check("sweep_p2y_c", bus1.p2y_c, gate2(4'(i)));
      tick();
    end

    // Reset mid-operation.
    set_in(6'b111000, 4'b1100);
    tick();
    check("prerst_p1y", bus1.p1y, 1'b1);
    check("prerst_p2y", bus1.p2y, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rst_p1y", bus1.p1y, 1'b0);
    check("rst_p2y", bus1.p2y, 1'b0);
    check("rst_p1y_c", bus1.p1y_c, 1'b1);
    check("rst_p2y_c", bus1.p2y_c, 1'b1);
    rst_n = 1'b1;
    tick();
    check("release_p1y", bus1.p1y, 1'b1);
    check("release_p2y", bus1.p2y, 1'b1);

    // Clock stopped, reset held: combinational build tracks inputs.
    clk_en = 1'b0;
    rst_n = 1'b0;
    #10;
    set_in(6'b000111, 4'b0000);
    #1;
    check("comb0_p1y", bus0.p1y, 1'b1);
    check("comb0_p2y", bus0.p2y, 1'b0);
    set_in(6'b000011, 4'b0011);
    #1;
    check("comb1_p1y", bus0.p1y, 1'b0);
    check("comb1_p2y", bus0.p2y, 1'b1);
    set_in(6'b111000, 4'b1100);
    #1;
    check("comb2_p1y", bus0.p1y, 1'b1);
    check("comb2_p2y", bus0.p2y, 1'b1);
    set_in(6'b110110, 4'b1010);
    #1;
    check("comb3_p1y", bus0.p1y, 1'b0);
    check("comb3_p2y", bus0.p2y, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
